// File: rtl/mod4_down_counter.sv
// Mod-4 down counter clocked by cp, decremented once per synchronized rising edge of x, with load and borrow pulse.
// Optional input debounce filter enabled by defining MOD4_DOWN_DEBOUNCE_EN (length set by DB_CYCLES).
module mod4_down_counter #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       cp,
  input  logic       rd,
  input  logic       x,
  input  logic       ld,
  input  logic [1:0] d,
  output logic       y2,
  output logic       y1,
  output logic       z
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] y_q, y_d;
  logic       z_q, z_d;
  logic       lvl;
  logic       cnt_ev;

`ifdef MOD4_DOWN_DEBOUNCE_EN
  // Filtered level follows s2 only after DB_CYCLES consecutive disagreeing cycles.
  logic       filt_q, filt_d;
  logic [7:0] db_cnt_q, db_cnt_d;

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (s2_q != filt_q) begin
      if (db_cnt_q == 8'(DB_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge cp) begin
    if (rd) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  assign cnt_ev = lvl & ~s3_q;

  always_comb begin
    y_d = y_q;
    z_d = 1'b0;
    if (ld) begin
      y_d = d;
    end else if (cnt_ev) begin
      y_d = y_q - 2'd1;
      z_d = (y_q == 2'b00);
    end
  end

  always_ff @(posedge cp) begin
    if (rd) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      y_q  <= '0;
      z_q  <= 1'b0;
    end else begin
      s1_q <= x;
      s2_q <= s1_q;
      s3_q <= lvl;
      y_q  <= y_d;
      z_q  <= z_d;
    end
  end

  assign y2 = y_q[1];
  assign y1 = y_q[0];
  assign z  = z_q;

endmodule
